// File: rtl/mem_access_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//   Shared encodings for the MEM pipeline stage: access-size codes, FSM state
//   codes and small combinational helpers for alignment and lane generation.
// ---------------------------------------------------------------------------
package mem_pkg;

    // Access size encodings carried on mem_size_in (code 3 behaves as word)
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // True when the low address bits suit the access size
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lsb);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (lsb[0] == 1'b0);
            default: ok = (lsb == 2'b00);
        endcase
        return ok;
    endfunction

    // Byte enables for a store of the given size at the given byte offset
    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lsb);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lsb;
            SZ_HALF: be = lsb[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane the size could target
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] lanes;
        case (size)
            SZ_BYTE: lanes = {4{wd[7:0]}};
            SZ_HALF: lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// ---------------------------------------------------------------------------
// load_align
//   Combinational load formatter: picks the addressed byte or halfword out of
//   the read word and sign- or zero-extends it to 32 bits.
// Ports
//   rdata_i     in  32  raw word from data memory
//   addr_lsb_i  in   2  byte offset within the word
//   size_i      in   2  access size (SZ_BYTE/SZ_HALF/word)
//   unsigned_i  in   1  1 = zero-extend, 0 = sign-extend
//   data_o      out 32  aligned, extended result
// ---------------------------------------------------------------------------
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lsb_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        byte_fill_s;
    logic        half_fill_s;

    // Lane selection for byte and halfword loads
    always_comb begin
        case (addr_lsb_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            default: byte_s = rdata_i[31:24];
        endcase
        if (addr_lsb_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
    end

    assign byte_fill_s = ~unsigned_i & byte_s[7];
    assign half_fill_s = ~unsigned_i & half_s[15];

    // Width extension of the selected lane
    always_comb begin
        case (size_i)
            SZ_BYTE: data_o = {{24{byte_fill_s}}, byte_s};
            SZ_HALF: data_o = {{16{half_fill_s}}, half_s};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//   MEM pipeline stage between EX/MEM and MEM/WB. Issues loads/stores over a
//   req/ready handshake, formats load data, generates byte enables and stalls
//   the upstream pipe while an access is outstanding. MEM/WB has no enable, so
//   a bubble (RegWrite_out=0) is presented on every stalled cycle.
// Ports
//   clk, reset (async, active-low)
//   EX/MEM side : RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
//                 mem_size_in[1:0], mem_unsigned_in, alu_result_in[31:0],
//                 write_data_in[31:0], write_reg_in[4:0]
//   Memory side : dmem_req, dmem_we, dmem_addr[31:0], dmem_wdata[31:0],
//                 dmem_be[3:0] (out); dmem_ready, dmem_rdata[31:0] (in)
//   Control     : stall_out
//   MEM/WB side : RegWrite_out, MemtoReg_out, mem_read_data_out[31:0],
//                 alu_result_out[31:0], write_reg_out[4:0]
//   Status      : misalign_out (suppressed access), mem_fault_out (timeout pulse)
// ---------------------------------------------------------------------------
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_unsigned_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic [4:0]  write_reg_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [31:0] mem_read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  write_reg_out,
    output logic        misalign_out,
    output logic        mem_fault_out
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO = TIMER_W'(0);

    logic [1:0]         state_q, state_d;
    logic [31:0]        data_q, data_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               fault_q, fault_d;

    logic               mem_op_s;
    logic               aligned_s;
    logic               req_s;
    logic               req_live_s;
    logic               regwrite_s;
    logic               misalign_s;
    logic               fault_pulse_s;
    logic [31:0]        load_data_s;

    assign mem_op_s  = MemRead_in | MemWrite_in;
    assign aligned_s = is_aligned(mem_size_in, alu_result_in[1:0]);

    load_align u_load_align (
        .rdata_i    (dmem_rdata),
        .addr_lsb_i (alu_result_in[1:0]),
        .size_i     (mem_size_in),
        .unsigned_i (mem_unsigned_in),
        .data_o     (load_data_s)
    );

    // Next-state, handshake and writeback-gating decode
    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        timer_d       = timer_q;
        fault_d       = fault_q;
        req_s         = 1'b0;
        regwrite_s    = RegWrite_in;
        misalign_s    = 1'b0;
        fault_pulse_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = TIMER_ZERO;
                fault_d = 1'b0;
                if (mem_op_s) begin
                    regwrite_s = 1'b0;
                    if (aligned_s) begin
                        req_s   = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        misalign_s = 1'b1;
                    end
                end else begin
                    regwrite_s = RegWrite_in;
                end
            end
            ST_WAIT: begin
                req_s      = 1'b1;
                regwrite_s = 1'b0;
                if (dmem_ready) begin
                    data_d  = load_data_s;
                    timer_d = TIMER_ZERO;
                    state_d = ST_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    // Abandon the access; DONE reports the fault and drops the write
                    fault_d = 1'b1;
                    timer_d = TIMER_ZERO;
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            ST_DONE: begin
                regwrite_s    = RegWrite_in & ~fault_q;
                fault_pulse_s = fault_q;
                fault_d       = 1'b0;
                state_d       = ST_IDLE;
            end
            default: begin
                regwrite_s = 1'b0;
                timer_d    = TIMER_ZERO;
                fault_d    = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // Stage state, captured load data, wait timer and fault flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            data_q  <= 32'd0;
            timer_q <= TIMER_ZERO;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            timer_q <= timer_d;
            fault_q <= fault_d;
        end
    end

    // Reset also masks the request combinationally so it drops the instant reset asserts
    assign req_live_s = req_s & reset;

    assign dmem_req   = req_live_s;
    assign stall_out  = req_live_s;
    assign dmem_we    = req_live_s & MemWrite_in;
    assign dmem_addr  = req_live_s ? {alu_result_in[31:2], 2'b00} : 32'd0;
    assign dmem_wdata = req_live_s ? store_lanes(mem_size_in, write_data_in) : 32'd0;
    assign dmem_be    = req_live_s ? byte_enables(mem_size_in, alu_result_in[1:0]) : 4'b0000;

    assign RegWrite_out      = regwrite_s;
    assign MemtoReg_out      = MemtoReg_in;
    assign mem_read_data_out = data_q;
    assign alu_result_out    = alu_result_in;
    assign write_reg_out     = write_reg_in;
    assign misalign_out      = misalign_s & reset;
    assign mem_fault_out     = fault_pulse_s;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
    logic [1:0]  mem_size_in;
    logic        mem_unsigned_in;
    logic [31:0] alu_result_in, write_data_in;
    logic [4:0]  write_reg_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall_out, RegWrite_out, MemtoReg_out;
    logic [31:0] mem_read_data_out, alu_result_out;
    logic [4:0]  write_reg_out;
    logic        misalign_out, mem_fault_out;

    int vectors = 0;
    int miscompares = 0;

    mem_access_stage dut (
        .clk (clk), .reset (reset),
        .RegWrite_in (RegWrite_in), .MemtoReg_in (MemtoReg_in),
        .MemRead_in (MemRead_in), .MemWrite_in (MemWrite_in),
        .mem_size_in (mem_size_in), .mem_unsigned_in (mem_unsigned_in),
        .alu_result_in (alu_result_in), .write_data_in (write_data_in),
        .write_reg_in (write_reg_in),
        .dmem_req (dmem_req), .dmem_we (dmem_we), .dmem_addr (dmem_addr),
        .dmem_wdata (dmem_wdata), .dmem_be (dmem_be),
        .dmem_ready (dmem_ready), .dmem_rdata (dmem_rdata),
        .stall_out (stall_out), .RegWrite_out (RegWrite_out),
        .MemtoReg_out (MemtoReg_out), .mem_read_data_out (mem_read_data_out),
        .alu_result_out (alu_result_out), .write_reg_out (write_reg_out),
        .misalign_out (misalign_out), .mem_fault_out (mem_fault_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_alu(input logic [31:0] res, input logic [4:0] rd);
        RegWrite_in = 1'b1; MemtoReg_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
        mem_size_in = 2'd2; mem_unsigned_in = 1'b0;
        alu_result_in = res; write_data_in = 32'h0; write_reg_in = rd;
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_alu(32'h0000_1111, 5'd3);
        MemRead_in = 1'b1;  // an op on the inputs must not request while in reset
        #3;
        vectors++;
        if ({dmem_req, dmem_we, stall_out, misalign_out, mem_fault_out} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b required 00000", {dmem_req, dmem_we, stall_out, misalign_out, mem_fault_out});
        end
        vectors++;
        if ({dmem_addr, dmem_wdata, dmem_be} !== 68'h0) begin
            miscompares++;
            $display("FAIL reset_bus: got addr %h wdata %h be %b required zeros", dmem_addr, dmem_wdata, dmem_be);
        end
        vectors++;
        if (mem_read_data_out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h required 00000000", mem_read_data_out);
        end
        MemRead_in = 1'b0;
        next_cycle();
        vectors++;
        if ({RegWrite_out, alu_result_out, write_reg_out} !== {1'b1, 32'h0000_1111, 5'd3}) begin
            miscompares++;
            $display("FAIL reset_pass: got %b %h %0d required 1 00001111 3", RegWrite_out, alu_result_out, write_reg_out);
        end
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic test_alu_pass();
        set_alu(32'h1234_5678, 5'd7);
        MemtoReg_in = 1'b1;
        dmem_ready = 1'b1;  // stray ready while idle must be ignored
        dmem_rdata = 32'hFFFF_FFFF;
        #1;
        vectors++;
        if ({RegWrite_out, MemtoReg_out, alu_result_out, write_reg_out, stall_out, dmem_req} !==
            {1'b1, 1'b1, 32'h1234_5678, 5'd7, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL alu_pass: got rw %b mtr %b alu %h rd %0d stall %b req %b required 1 1 12345678 7 0 0",
                     RegWrite_out, MemtoReg_out, alu_result_out, write_reg_out, stall_out, dmem_req);
        end
        next_cycle();
        RegWrite_in = 1'b0;
        #1;
        vectors++;
        if ({RegWrite_out, stall_out, mem_read_data_out} !== {1'b0, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL alu_idle_ready: got rw %b stall %b data %h required 0 0 00000000",
                     RegWrite_out, stall_out, mem_read_data_out);
        end
        dmem_ready = 1'b0;
    endtask

    // Load with ready on the first WAIT cycle: two stall cycles, then DONE
    task automatic do_load(input string nm, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] rdata, input logic [31:0] exp_data);
        RegWrite_in = 1'b1; MemtoReg_in = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b0;
        mem_size_in = size; mem_unsigned_in = uns; alu_result_in = addr;
        write_data_in = 32'h0; write_reg_in = 5'd9; dmem_ready = 1'b0; dmem_rdata = 32'h0;
        #1;
        vectors++;
        if ({dmem_req, dmem_we, stall_out, RegWrite_out, misalign_out, dmem_addr} !==
            {5'b10100, addr & 32'hFFFF_FFFC}) begin
            miscompares++;
            $display("FAIL %s_issue: got req %b we %b stall %b rw %b mis %b addr %h required 1 0 1 0 0 %h",
                     nm, dmem_req, dmem_we, stall_out, RegWrite_out, misalign_out, dmem_addr, addr & 32'hFFFF_FFFC);
        end
        next_cycle();
        dmem_ready = 1'b1; dmem_rdata = rdata;
        #1;
        vectors++;
        if ({dmem_req, stall_out, RegWrite_out} !== 3'b110) begin
            miscompares++;
            $display("FAIL %s_wait: got req %b stall %b rw %b required 1 1 0", nm, dmem_req, stall_out, RegWrite_out);
        end
        next_cycle();
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
        #1;
        vectors++;
        if ({dmem_req, stall_out, RegWrite_out, mem_fault_out, write_reg_out} !== {4'b0010, 5'd9}) begin
            miscompares++;
            $display("FAIL %s_done: got req %b stall %b rw %b fault %b rd %0d required 0 0 1 0 9",
                     nm, dmem_req, stall_out, RegWrite_out, mem_fault_out, write_reg_out);
        end
        vectors++;
        if (mem_read_data_out !== exp_data) begin
            miscompares++;
            $display("FAIL %s_data: got %h required %h", nm, mem_read_data_out, exp_data);
        end
        next_cycle();
    endtask

    task automatic test_loads();
        do_load("lw",     32'h0000_0100, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load("lb_s",   32'h0000_0103, 2'd0, 1'b0, 32'h80FF_FFFF, 32'hFFFF_FF80);
        do_load("lb_u",   32'h0000_0103, 2'd0, 1'b1, 32'h80FF_FFFF, 32'h0000_0080);
        do_load("lb_l1",  32'h0000_0101, 2'd0, 1'b0, 32'h1234_5678, 32'h0000_0056);
        do_load("lh_s",   32'h0000_0102, 2'd1, 1'b0, 32'h8001_1234, 32'hFFFF_8001);
        do_load("lh_u",   32'h0000_0102, 2'd1, 1'b1, 32'h8001_1234, 32'h0000_8001);
        do_load("lh_lo",  32'h0000_0100, 2'd1, 1'b0, 32'h8001_7FFE, 32'h0000_7FFE);
        do_load("lw_sz3", 32'h0000_0104, 2'd3, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D);
        set_alu(32'h0, 5'd0);
    endtask

    // Store held for 'waits' extra WAIT cycles before ready
    task automatic do_store(input string nm, input logic [31:0] addr, input logic [1:0] size,
                            input logic rd_too, input logic [31:0] wd, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input int waits);
        RegWrite_in = 1'b0; MemtoReg_in = 1'b0; MemRead_in = rd_too; MemWrite_in = 1'b1;
        mem_size_in = size; mem_unsigned_in = 1'b0; alu_result_in = addr;
        write_data_in = wd; write_reg_in = 5'd0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
        #1;
        vectors++;
        if ({dmem_req, dmem_we, stall_out, dmem_be, dmem_wdata, dmem_addr} !==
            {3'b111, exp_be, exp_wdata, addr & 32'hFFFF_FFFC}) begin
            miscompares++;
            $display("FAIL %s_issue: got req %b we %b stall %b be %b wdata %h addr %h required 1 1 1 %b %h %h",
                     nm, dmem_req, dmem_we, stall_out, dmem_be, dmem_wdata, dmem_addr,
                     exp_be, exp_wdata, addr & 32'hFFFF_FFFC);
        end
        for (int i = 0; i < waits; i++) begin
            next_cycle();
            vectors++;
            if ({dmem_req, dmem_we, stall_out, dmem_be} !== {3'b111, exp_be}) begin
                miscompares++;
                $display("FAIL %s_hold%0d: got req %b we %b stall %b be %b required 1 1 1 %b",
                         nm, i, dmem_req, dmem_we, stall_out, dmem_be, exp_be);
            end
        end
        next_cycle();
        dmem_ready = 1'b1;
        next_cycle();
        dmem_ready = 1'b0;
        #1;
        vectors++;
        if ({dmem_req, dmem_we, stall_out, RegWrite_out, mem_fault_out} !== 5'b00000) begin
            miscompares++;
            $display("FAIL %s_done: got req %b we %b stall %b rw %b fault %b required 0 0 0 0 0",
                     nm, dmem_req, dmem_we, stall_out, RegWrite_out, mem_fault_out);
        end
        next_cycle();
    endtask

    task automatic test_stores();
        do_store("sh",    32'h0000_0102, 2'd1, 1'b0, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, 2);
        do_store("sb_rw", 32'h0000_0101, 2'd0, 1'b1, 32'h7777_775A, 4'b0010, 32'h5A5A_5A5A, 0);
        do_store("sw",    32'h0000_0208, 2'd2, 1'b0, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D, 1);
        set_alu(32'h0, 5'd0);
    endtask

    task automatic test_misalign();
        set_alu(32'h0000_0101, 5'd4);
        MemRead_in = 1'b1;
        #1;
        vectors++;
        if ({dmem_req, stall_out, misalign_out, RegWrite_out} !== 4'b0010) begin
            miscompares++;
            $display("FAIL mis_lw: got req %b stall %b mis %b rw %b required 0 0 1 0",
                     dmem_req, stall_out, misalign_out, RegWrite_out);
        end
        next_cycle();
        mem_size_in = 2'd1; alu_result_in = 32'h0000_0103; MemRead_in = 1'b0; MemWrite_in = 1'b1;
        #1;
        vectors++;
        if ({dmem_req, dmem_we, stall_out, misalign_out, RegWrite_out} !== 5'b00010) begin
            miscompares++;
            $display("FAIL mis_sh: got req %b we %b stall %b mis %b rw %b required 0 0 0 1 0",
                     dmem_req, dmem_we, stall_out, misalign_out, RegWrite_out);
        end
        next_cycle();
        set_alu(32'h0000_0103, 5'd4);
        #1;
        vectors++;
        if ({misalign_out, RegWrite_out} !== 2'b01) begin
            miscompares++;
            $display("FAIL mis_clear: got mis %b rw %b required 0 1", misalign_out, RegWrite_out);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        int stalls;
        set_alu(32'h0000_0200, 5'd12);
        MemRead_in = 1'b1; MemtoReg_in = 1'b1;
        #1;
        stalls = 0;
        while (stall_out === 1'b1 && stalls < 40) begin
            stalls++;
            next_cycle();
        end
        vectors++;
        if (stalls !== 17) begin
            miscompares++;
            $display("FAIL timeout_stalls: got %0d stall cycles required 17", stalls);
        end
        vectors++;
        if ({mem_fault_out, RegWrite_out, dmem_req} !== 3'b100) begin
            miscompares++;
            $display("FAIL timeout_done: got fault %b rw %b req %b required 1 0 0", mem_fault_out, RegWrite_out, dmem_req);
        end
        next_cycle();
        set_alu(32'h0000_0055, 5'd12);
        #1;
        vectors++;
        if ({mem_fault_out, RegWrite_out, stall_out} !== 3'b010) begin
            miscompares++;
            $display("FAIL timeout_after: got fault %b rw %b stall %b required 0 1 0", mem_fault_out, RegWrite_out, stall_out);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        set_alu(32'h0000_0300, 5'd2);
        MemRead_in = 1'b1;
        next_cycle();
        vectors++;
        if ({dmem_req, stall_out} !== 2'b11) begin
            miscompares++;
            $display("FAIL rst_mid_wait: got req %b stall %b required 1 1", dmem_req, stall_out);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({dmem_req, stall_out, mem_read_data_out} !== {2'b00, 32'h0}) begin
            miscompares++;
            $display("FAIL rst_mid_drop: got req %b stall %b data %h required 0 0 00000000",
                     dmem_req, stall_out, mem_read_data_out);
        end
        next_cycle();
        reset = 1'b1;
        set_alu(32'h0000_ABCD, 5'd6);
        #1;
        vectors++;
        if ({RegWrite_out, alu_result_out, write_reg_out, stall_out, dmem_req} !==
            {1'b1, 32'h0000_ABCD, 5'd6, 2'b00}) begin
            miscompares++;
            $display("FAIL rst_mid_pass: got rw %b alu %h rd %0d stall %b req %b required 1 0000abcd 6 0 0",
                     RegWrite_out, alu_result_out, write_reg_out, stall_out, dmem_req);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        do_load("b2b_a", 32'h0000_0400, 2'd2, 1'b0, 32'h0102_0304, 32'h0102_0304);
        do_load("b2b_b", 32'h0000_0402, 2'd1, 1'b0, 32'hF00F_0000, 32'hFFFF_F00F);
        set_alu(32'h0, 5'd0);
        next_cycle();
    endtask

    initial begin
        set_alu(32'h0, 5'd0);
        reset = 1'b0;
        test_reset();
        test_alu_pass();
        test_loads();
        test_stores();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
